timer_event_queue: RTL

Downstream consumer of the interval timer's interrupt output. The block timestamps each timer interrupt event with the timer's tick counter and stores it in a small show-ahead FIFO. It raises a level IRQ to the CPU once a programmable number of events is pending, so software can drain bursts of ticks without losing their times. It sits between the timer and the interrupt controller, and takes configuration writes on the same ISI-style byte-enabled write port as the timer.

---
 rtl/timer_event_queue_if.sv | 29 ++
 rtl/timer_event_queue.sv | 127 ++++++++++++
 2 files changed

// File: rtl/timer_event_queue_if.sv
// Bus bundle for timer_event_queue: timer event input, config write port,
// pop strobe and the FIFO/status outputs.
interface timer_event_queue_if #(
    parameter int CW = 4
);
    logic        INTR;
    logic [31:0] TCNTR;
    logic        ACT;
    logic [7:0]  BE;
    logic [63:0] DI;
    logic        RD;
    logic [31:0] DO;
    logic        EMPTY;
    logic        FULL;
    logic [CW-1:0] CNT;
    logic        OVF;
    logic [7:0]  DROPS;
    logic        IRQ;

    modport master (
        output INTR, TCNTR, ACT, BE, DI, RD,
        input  DO, EMPTY, FULL, CNT, OVF, DROPS, IRQ
    );

    modport slave (
        input  INTR, TCNTR, ACT, BE, DI, RD,
        output DO, EMPTY, FULL, CNT, OVF, DROPS, IRQ
    );
endinterface

// File: rtl/timer_event_queue.sv
// Timestamps rising edges of the timer interrupt into a show-ahead FIFO and
// raises a level IRQ once a programmable number of events is pending.
module timer_event_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    timer_event_queue_if.slave    bus
);
    localparam int PW = CW - 1;

    logic [31:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s, lvl_r, lvl_nxt_s, lvl_in_s;
    logic [31:0]   do_r, do_nxt_s;
    logic [7:0]    drops_r, drops_nxt_s;
    logic          intr_d_r, ena_r, ena_nxt_s, ovf_r, ovf_nxt_s;
    logic          empty_r, full_r, irq_r;
    logic          event_s, cfg0_s, cfg1_s, clr_s, flush_s;
    logic          is_full_s, is_empty_s, push_s, pop_s, drop_s;
    logic          unused_s;

    // Next-state computation for pointers, count, head, status and config
    always_comb begin
        event_s    = bus.INTR & ~intr_d_r;
        cfg0_s     = bus.ACT & ~bus.BE[0];
        cfg1_s     = bus.ACT & ~bus.BE[1];
        clr_s      = cfg1_s & bus.DI[8];
        flush_s    = cfg1_s & bus.DI[9];
        is_full_s  = (cnt_r == CW'(DEPTH));
        is_empty_s = (cnt_r == {CW{1'b0}});
        // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it
        push_s     = event_s & (~is_full_s | bus.RD) & ~flush_s;
        pop_s      = bus.RD & ~is_empty_s & ~flush_s;
        drop_s     = event_s & is_full_s & ~bus.RD & ~flush_s;

        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        cnt_nxt_s    = cnt_r;
        if (flush_s) begin
            wr_ptr_nxt_s = {PW{1'b0}};
            rd_ptr_nxt_s = {PW{1'b0}};
            cnt_nxt_s    = {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_nxt_s = wr_ptr_r + PW'(1);
            else        wr_ptr_nxt_s = wr_ptr_r;
            if (pop_s)  rd_ptr_nxt_s = rd_ptr_r + PW'(1);
            else        rd_ptr_nxt_s = rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   cnt_nxt_s = cnt_r + CW'(1);
                2'b01:   cnt_nxt_s = cnt_r - CW'(1);
                default: cnt_nxt_s = cnt_r;
            endcase
        end

        // The head may be the entry being written this very cycle
        if (cnt_nxt_s == {CW{1'b0}})                     do_nxt_s = 32'h0000_0000;
        else if (push_s && (wr_ptr_r == rd_ptr_nxt_s))   do_nxt_s = bus.TCNTR;
        else                                             do_nxt_s = mem_r[rd_ptr_nxt_s];

        if (clr_s)       ovf_nxt_s = 1'b0;
        else if (drop_s) ovf_nxt_s = 1'b1;
        else             ovf_nxt_s = ovf_r;

        if (clr_s)                           drops_nxt_s = 8'd0;
        else if (drop_s && drops_r != 8'hFF) drops_nxt_s = drops_r + 8'd1;
        else                                 drops_nxt_s = drops_r;

        lvl_in_s = bus.DI[CW-1:0];
        if (!cfg0_s)                           lvl_nxt_s = lvl_r;
        else if (lvl_in_s == {CW{1'b0}})       lvl_nxt_s = CW'(1);
        else if (lvl_in_s > CW'(DEPTH))        lvl_nxt_s = CW'(DEPTH);
        else                                   lvl_nxt_s = lvl_in_s;

        if (cfg0_s) ena_nxt_s = bus.DI[7];
        else        ena_nxt_s = ena_r;
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            do_r     <= 32'h0000_0000;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
            drops_r  <= 8'd0;
            irq_r    <= 1'b0;
            ena_r    <= 1'b0;
            lvl_r    <= CW'(1);
            intr_d_r <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            cnt_r    <= cnt_nxt_s;
            do_r     <= do_nxt_s;
            empty_r  <= (cnt_nxt_s == {CW{1'b0}});
            full_r   <= (cnt_nxt_s == CW'(DEPTH));
            ovf_r    <= ovf_nxt_s;
            drops_r  <= drops_nxt_s;
            irq_r    <= ena_r & (cnt_r >= lvl_r);
            ena_r    <= ena_nxt_s;
            lvl_r    <= lvl_nxt_s;
            intr_d_r <= bus.INTR;
        end
    end

    // Timestamp storage; stale contents are harmless because pointers and DO reset
    always_ff @(posedge CLK) begin
        if (RESET && push_s) begin
            mem_r[wr_ptr_r] <= bus.TCNTR;
        end
    end

    assign bus.DO    = do_r;
    assign bus.EMPTY = empty_r;
    assign bus.FULL  = full_r;
    assign bus.CNT   = cnt_r;
    assign bus.OVF   = ovf_r;
    assign bus.DROPS = drops_r;
    assign bus.IRQ   = irq_r;

    assign unused_s = ^{bus.DI[63:10], bus.DI[6:CW], bus.BE[7:2]};
endmodule
